exe_muldiv_ctrl: RTL
====================

Name: exe_muldiv_ctrl

Overview:
Iterative multiply/divide unit and its sequencer for the execute stage of the 5-stage RV32 pipeline. It accepts an M-extension op from E, holds the pipeline with a stall until the result is ready, and runs a radix-2 shift-add multiplier or restoring divider for XLEN cycles. It then presents the result for one cycle so the E/M pipeline register captures it in place of ALUResultE. The hazard unit ORs stall_o into StallF/StallD/StallE, and flush_i aborts the operation.

Parameters:
XLEN, 32, operand/result width; also the iteration count
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
start_i  input  1  valid M-op in E stage (MulDivE & ~FlushE)
op_i  input  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
a_i  input  XLEN  forwarded SrcAE
b_i  input  XLEN  forwarded SrcB (register path, never immediate)
flush_i  input  1  E-stage flush (branch taken / exception)
stall_o  output  1  hold F/D/E stages
busy_o  output  1  state != IDLE
done_o  output  1  result valid this cycle
result_o  output  XLEN  op result, valid when done_o

Behaviour:
- Reset: rst is asynchronous and active-low, with clock clk. On reset the state is IDLE and stall_o=0, busy_o=0, done_o=0, result_o=0. Reset asserted mid-operation returns the block to IDLE with all internal registers cleared.
- States: IDLE, BUSY, DONE.
- IDLE, start_i=1, flush_i=0:
  - Latch op, a_i and b_i.
  - Clear acc (2*XLEN bits) and cnt=0.
  - Go to BUSY.
  - stall_o=1 combinationally in this same cycle.
- BUSY performs one iteration per cycle, with cnt incrementing.
  - MUL/MULHU: if multiplier LSB=1, add the multiplicand into the upper half of acc; then shift {carry,acc} right by 1.
  - DIVU/REMU: shift {rem,quot} left by 1, trial-subtract the divisor, keep the result if non-negative, and set the quotient LSB accordingly.
  - When cnt==XLEN-1, latch the result and go to DONE. BUSY therefore lasts exactly XLEN cycles.
- Divide-by-zero (b==0 with DIVU/REMU): detected in IDLE at start. Skip BUSY and go straight to DONE on the next cycle.
  - DIVU result = all ones.
  - REMU result = a.
- DONE: done_o=1, stall_o=0, result_o valid. Always go to IDLE next cycle, even if start_i is still high. A new start is accepted only in IDLE.
- Result selection:
  - MUL = product[XLEN-1:0].
  - MULHU = product[2XLEN-1:XLEN].
  - DIVU = quotient.
  - REMU = remainder.
  - All arithmetic is unsigned and never overflows the 2*XLEN-bit product.
- stall_o = start_i & ~flush_i & (state==IDLE | state==BUSY).
- Latency: with start seen at T0, stall_o is high T0..T0+XLEN and done_o is high at T0+XLEN+1 (T0+1 for divide-by-zero). For XLEN=32 that is 33 stall cycles.
- flush_i in any state: next state is IDLE, stall_o=0 that cycle, and no done_o is produced. flush_i has priority over start_i and over the BUSY→DONE transition.
- result_o holds its last value outside DONE. Only done_o qualifies it.
- Operand changes on a_i/b_i while BUSY are ignored.

Test Plan:
- MUL 7×6 at T0 → stall_o high T0..T32; done_o=1 and result_o=42 at T33; IDLE at T34.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result_o=0xFFFFFFFE; repeat as MUL → 0x00000001.
- DIVU 100/7 → 14, REMU 100/7 → 2. DIVU 0x80000000/1 → 0x80000000. Each has done_o at T0+33.
- DIVU 0x1234/0 → 0xFFFFFFFF, REMU 0x1234/0 → 0x1234, each with done_o at T0+1 and stall_o high only at T0.
- Two back-to-back MULs (start_i held, operands change after DONE) → two done_o pulses 34 cycles apart with correct results, and no restart in DONE.
- flush_i at BUSY cycle 5 → IDLE next cycle, stall_o=0 in the flush cycle, no done_o. Separately, rst low at BUSY cycle 10 → all outputs 0 immediately; a MUL 3×3 after reset returns 9.

Source files
------------

// File: rtl/exe_muldiv_ctrl.sv
// rtl/exe_muldiv_ctrl.sv - iterative RV32 M-extension multiply/divide unit with pipeline stall
module exe_muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_md;
  logic [XLEN-1:0]   r_x;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_div0;
  logic              w_last;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0]   w_x_nxt;
  logic [XLEN-1:0]   w_iter_result;

  assign w_accept = (r_state == S_IDLE) & start_i & ~flush_i;
  assign w_div0   = op_i[1] & (b_i == '0);
  assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

  // r_md is the multiplicand or divisor; r_x is the multiplier (shifts out LSB-first)
  // or the dividend that turns into the quotient (shifts out MSB-first).
  always_comb begin
    w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_x[0] ? {1'b0, r_md} : '0);
    w_rem_sh = {r_acc[2*XLEN-1:XLEN], r_x[XLEN-1]};
    w_diff   = w_rem_sh - {1'b0, r_md};
    if (r_op[1]) begin
      w_acc_nxt = {(w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0]), {XLEN{1'b0}}};
      w_x_nxt   = {r_x[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
      w_x_nxt   = {1'b0, r_x[XLEN-1:1]};
    end
    case (r_op)
      2'b00:   w_iter_result = w_acc_nxt[XLEN-1:0];
      2'b10:   w_iter_result = w_x_nxt;
      default: w_iter_result = w_acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start_i) w_state_nxt = w_div0 ? S_DONE : S_BUSY;
        S_BUSY:  if (w_last) w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Gating with rst keeps stall low during reset even if E still presents an M-op.
  always_comb begin
    stall_o = rst & start_i & ~flush_i & ((r_state == S_IDLE) | (r_state == S_BUSY));
    busy_o  = (r_state != S_IDLE);
    done_o  = (r_state == S_DONE);
  end

  assign result_o = r_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_md     <= '0;
      r_x      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= op_i;
      r_md  <= b_i;
      r_x   <= a_i;
      r_acc <= '0;
      r_cnt <= '0;
      if (w_div0) r_result <= op_i[0] ? a_i : {XLEN{1'b1}};
    end else if ((r_state == S_BUSY) && !flush_i) begin
      r_acc <= w_acc_nxt;
      r_x   <= w_x_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_iter_result;
    end
  end

endmodule
